// File: rtl/trap_irq_ctrl_if.sv
// Core-side bundle between decoder/PC logic and the trap/interrupt controller.
// Master is the core, slave is the controller.
interface trap_irq_ctrl_if #(
  parameter int NUM_IRQ    = 4,
  parameter int NEST_DEPTH = 3,
  parameter int XLEN       = 32
);
  localparam int LW = $clog2(NUM_IRQ + 2);
  localparam int DW = $clog2(NEST_DEPTH + 1);

  logic               instr_valid;
  logic [NUM_IRQ-1:0] irq_req;
  logic               ecall;
  logic               uret;
  logic               csrsi;
  logic               csrci;
  logic [XLEN-1:0]    pc_cur;
  logic [XLEN-1:0]    pc_next;

  logic               trap_take;
  logic [XLEN-1:0]    trap_pc;
  logic [LW-1:0]      trap_id;
  logic               ret_take;
  logic [XLEN-1:0]    ret_pc;
  logic               mie;
  logic [NUM_IRQ-1:0] pending;
  logic [DW-1:0]      depth;
  logic [LW-1:0]      active_level;
  logic               err_ovf;
  logic               err_udf;

  modport master (
    output instr_valid, irq_req, ecall, uret, csrsi, csrci, pc_cur, pc_next,
    input  trap_take, trap_pc, trap_id, ret_take, ret_pc, mie, pending,
           depth, active_level, err_ovf, err_udf
  );

  modport slave (
    input  instr_valid, irq_req, ecall, uret, csrsi, csrci, pc_cur, pc_next,
    output trap_take, trap_pc, trap_id, ret_take, ret_pc, mie, pending,
           depth, active_level, err_ovf, err_udf
  );
endinterface

// File: rtl/trap_irq_ctrl.sv
// Fixed-priority trap/interrupt controller with a nested return-address stack.
// Latency: redirects combinational in the retiring cycle; state updates on the next edge.
// Backpressure: instr_valid=0 stalls all redirects and stack/mie changes; requests keep latching.
module trap_irq_ctrl #(
  parameter int              NUM_IRQ    = 4,
  parameter int              NEST_DEPTH = 3,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] VEC_BASE   = 'h0000_0100,
  parameter logic [XLEN-1:0] ECALL_VEC  = 'h0000_0080
) (
  input logic            clk,
  input logic            rst,
  trap_irq_ctrl_if.slave bus
);
  localparam int LW = $clog2(NUM_IRQ + 2);
  localparam int DW = $clog2(NEST_DEPTH + 1);
  localparam logic [LW-1:0] ECALL_LVL = LW'(NUM_IRQ + 1);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic               mie;
  logic [DW-1:0]      depth;
  logic               err_ovf;
  logic               err_udf;
  logic [XLEN-1:0]    stk_pc  [NEST_DEPTH];
  logic [LW-1:0]      stk_lvl [NEST_DEPTH];

  logic               full;
  logic               empty;
  logic [DW-1:0]      top_idx;
  logic [LW-1:0]      active_level;
  logic [LW-1:0]      cand;
  logic [LW-1:0]      cand_lvl;
  logic               ecall_ok;
  logic               uret_ok;
  logic               irq_ok;
  logic               ovf_evt;
  logic               udf_evt;
  logic [NUM_IRQ-1:0] pend_clr;

  assign full         = (depth == DW'(NEST_DEPTH));
  assign empty        = (depth == '0);
  assign top_idx      = empty ? '0 : depth - DW'(1);
  assign active_level = empty ? '0 : stk_lvl[top_idx];

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending[i]) cand = LW'(i);
    end
  end
  assign cand_lvl = cand + LW'(1);

  // ecall beats uret beats interrupts; a deferred interrupt simply stays pending.
  assign ecall_ok = bus.instr_valid && bus.ecall && !full;
  assign uret_ok  = bus.instr_valid && bus.uret && !bus.ecall && !empty;
  assign irq_ok   = bus.instr_valid && mie && (|pending) && (cand_lvl > active_level)
                    && !full && !bus.ecall && !bus.uret;
  assign ovf_evt  = bus.instr_valid && bus.ecall && full;
  assign udf_evt  = bus.instr_valid && bus.uret && !bus.ecall && empty;
  assign pend_clr = irq_ok ? (NUM_IRQ'(1) << cand) : '0;

  assign bus.trap_take    = ecall_ok || irq_ok;
  assign bus.trap_pc      = ecall_ok ? ECALL_VEC :
                            irq_ok   ? VEC_BASE + (XLEN'(cand) << 2) : '0;
  assign bus.trap_id      = ecall_ok ? ECALL_LVL : irq_ok ? cand_lvl : '0;
  assign bus.ret_take     = uret_ok;
  assign bus.ret_pc       = uret_ok ? stk_pc[top_idx] : '0;
  assign bus.mie          = mie;
  assign bus.pending      = pending;
  assign bus.depth        = depth;
  assign bus.active_level = active_level;
  assign bus.err_ovf      = err_ovf;
  assign bus.err_udf      = err_udf;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q   <= bus.irq_req;
      pending <= '0;
      mie     <= 1'b0;
      depth   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      irq_q   <= bus.irq_req;
      pending <= (pending & ~pend_clr) | (bus.irq_req & ~irq_q);
      if (bus.instr_valid) begin
        if (bus.csrci)      mie <= 1'b0;
        else if (bus.csrsi) mie <= 1'b1;
      end
      if (ecall_ok || irq_ok) depth <= depth + DW'(1);
      else if (uret_ok)       depth <= depth - DW'(1);
      if (ovf_evt) err_ovf <= 1'b1;
      if (udf_evt) err_udf <= 1'b1;
    end
  end

  // Frame storage needs no reset: depth alone says which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && ecall_ok) begin
      stk_pc[depth]  <= bus.pc_cur + XLEN'(4);
      stk_lvl[depth] <= ECALL_LVL;
    end else if (!rst && irq_ok) begin
      stk_pc[depth]  <= bus.pc_next;
      stk_lvl[depth] <= cand_lvl;
    end
  end
endmodule

// File: tb/tb_trap_irq_ctrl.sv
// Directed vector bench for trap_irq_ctrl: a cycle table plus a stall/timeout sequence.
module tb_trap_irq_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_irq_ctrl_if #(.NUM_IRQ(4), .NEST_DEPTH(3), .XLEN(32)) bus ();

  trap_irq_ctrl #(
    .NUM_IRQ(4), .NEST_DEPTH(3), .XLEN(32),
    .VEC_BASE(32'h0000_0100), .ECALL_VEC(32'h0000_0080)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rst, iv;
    logic [3:0]  irq;
    logic        ec, ur, si, ci;
    logic [31:0] pcc, pcn;
    logic        tt;
    logic [31:0] tpc;
    logic [2:0]  tid;
    logic        rt;
    logic [31:0] rpc;
    logic        mie;
    logic [3:0]  pend;
    logic [1:0]  dep;
    logic [2:0]  al;
    logic        ovf, udf;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(
    input logic r, input logic iv, input logic [3:0] irq,
    input logic ec, input logic ur, input logic si, input logic ci,
    input logic [31:0] pcc, input logic [31:0] pcn,
    input logic tt, input logic [31:0] tpc, input logic [2:0] tid,
    input logic rt, input logic [31:0] rpc,
    input logic mie, input logic [3:0] pend, input logic [1:0] dep,
    input logic [2:0] al, input logic ovf, input logic udf);
    vec_t v;
    v.rst = r;  v.iv = iv;  v.irq = irq; v.ec = ec; v.ur = ur; v.si = si; v.ci = ci;
    v.pcc = pcc; v.pcn = pcn; v.tt = tt; v.tpc = tpc; v.tid = tid; v.rt = rt; v.rpc = rpc;
    v.mie = mie; v.pend = pend; v.dep = dep; v.al = al; v.ovf = ovf; v.udf = udf;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [3:0] irq, input logic ec,
                       input logic ur, input logic si, input logic ci,
                       input logic [31:0] pcc, input logic [31:0] pcn);
    rst = r; bus.instr_valid = iv; bus.irq_req = irq; bus.ecall = ec; bus.uret = ur;
    bus.csrsi = si; bus.csrci = ci; bus.pc_cur = pcc; bus.pc_next = pcn;
  endtask

  initial begin
    //  rst iv irq     ec ur si ci pc_cur      pc_next      tt trap_pc      id rt ret_pc       mie pend    dp al ovf udf
    add(0, 1, 4'b0000, 0, 0, 0, 0, 32'h000, 32'h004, 0, 32'h000, 0, 0, 32'h000, 0, 4'b0000, 0, 0, 0, 0); // reset state
    add(0, 1, 4'b0000, 0, 0, 1, 0, 32'h004, 32'h008, 0, 32'h000, 0, 0, 32'h000, 0, 4'b0000, 0, 0, 0, 0); // csrsi
    add(0, 1, 4'b0010, 0, 0, 0, 0, 32'h008, 32'h00C, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 0, 0, 0, 0); // ch1 rises
    add(0, 1, 4'b0010, 0, 0, 0, 0, 32'h03C, 32'h040, 1, 32'h104, 2, 0, 32'h000, 1, 4'b0010, 0, 0, 0, 0); // ch1 taken
    add(0, 1, 4'b1010, 0, 0, 0, 0, 32'h104, 32'h108, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 1, 2, 0, 0); // ch3 rises
    add(0, 1, 4'b1011, 0, 0, 0, 0, 32'h10C, 32'h110, 1, 32'h10C, 4, 0, 32'h000, 1, 4'b1000, 1, 2, 0, 0); // ch3 nests, ch0 rises
    add(0, 1, 4'b1011, 0, 0, 0, 0, 32'h11C, 32'h120, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0001, 2, 4, 0, 0); // ch0 below level
    add(0, 1, 4'b1011, 0, 1, 0, 0, 32'h120, 32'h124, 0, 32'h000, 0, 1, 32'h110, 1, 4'b0001, 2, 4, 0, 0); // uret from ch3
    add(0, 1, 4'b1011, 0, 0, 0, 0, 32'h110, 32'h114, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0001, 1, 2, 0, 0); // still in ch1
    add(0, 1, 4'b1011, 0, 1, 0, 0, 32'h114, 32'h118, 0, 32'h000, 0, 1, 32'h040, 1, 4'b0001, 1, 2, 0, 0); // uret from ch1
    add(0, 1, 4'b1011, 0, 0, 0, 0, 32'h040, 32'h044, 1, 32'h100, 1, 0, 32'h000, 1, 4'b0001, 0, 0, 0, 0); // ch0 taken
    add(0, 1, 4'b1011, 0, 1, 0, 0, 32'h100, 32'h104, 0, 32'h000, 0, 1, 32'h044, 1, 4'b0000, 1, 1, 0, 0); // uret from ch0
    add(0, 1, 4'b0000, 0, 0, 0, 0, 32'h044, 32'h048, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 0, 0, 0, 0);
    add(0, 1, 4'b0100, 0, 0, 0, 0, 32'h048, 32'h04C, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 0, 0, 0, 0); // ch2 rises
    add(0, 1, 4'b0100, 1, 0, 0, 0, 32'h200, 32'h204, 1, 32'h080, 5, 0, 32'h000, 1, 4'b0100, 0, 0, 0, 0); // ecall beats ch2
    add(0, 1, 4'b0100, 0, 0, 0, 0, 32'h080, 32'h084, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0100, 1, 5, 0, 0); // ch2 held
    add(0, 1, 4'b0100, 0, 1, 0, 0, 32'h084, 32'h088, 0, 32'h000, 0, 1, 32'h204, 1, 4'b0100, 1, 5, 0, 0); // uret to 0x204
    add(0, 1, 4'b0100, 0, 0, 0, 0, 32'h204, 32'h208, 1, 32'h108, 3, 0, 32'h000, 1, 4'b0100, 0, 0, 0, 0); // ch2 taken
    add(0, 1, 4'b0100, 1, 0, 0, 0, 32'h300, 32'h304, 1, 32'h080, 5, 0, 32'h000, 1, 4'b0000, 1, 3, 0, 0); // ecall nests
    add(0, 1, 4'b0100, 1, 0, 0, 0, 32'h400, 32'h404, 1, 32'h080, 5, 0, 32'h000, 1, 4'b0000, 2, 5, 0, 0); // stack full after
    add(0, 1, 4'b0100, 1, 0, 0, 0, 32'h500, 32'h504, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 3, 5, 0, 0); // overflow ecall
    add(0, 1, 4'b0100, 0, 0, 0, 0, 32'h504, 32'h508, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 3, 5, 1, 0); // err_ovf sticky
    add(0, 1, 4'b0100, 0, 1, 0, 0, 32'h508, 32'h50C, 0, 32'h000, 0, 1, 32'h404, 1, 4'b0000, 3, 5, 1, 0);
    add(0, 1, 4'b0100, 0, 1, 0, 0, 32'h404, 32'h408, 0, 32'h000, 0, 1, 32'h304, 1, 4'b0000, 2, 5, 1, 0);
    add(0, 1, 4'b0100, 0, 1, 0, 0, 32'h304, 32'h308, 0, 32'h000, 0, 1, 32'h208, 1, 4'b0000, 1, 3, 1, 0);
    add(0, 1, 4'b0100, 0, 1, 0, 0, 32'h208, 32'h20C, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 0, 0, 1, 0); // underflow uret
    add(0, 1, 4'b0100, 0, 0, 0, 0, 32'h20C, 32'h210, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 0, 0, 1, 1); // err_udf sticky
    add(1, 1, 4'b0001, 0, 0, 0, 0, 32'h210, 32'h214, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 0, 0, 1, 1); // reset, ch0 high
    add(0, 1, 4'b0001, 0, 0, 0, 0, 32'h000, 32'h004, 0, 32'h000, 0, 0, 32'h000, 0, 4'b0000, 0, 0, 0, 0); // all cleared
    add(0, 1, 4'b0000, 0, 0, 0, 0, 32'h004, 32'h008, 0, 32'h000, 0, 0, 32'h000, 0, 4'b0000, 0, 0, 0, 0); // no req from reset-high
    add(0, 1, 4'b0001, 0, 0, 0, 0, 32'h008, 32'h00C, 0, 32'h000, 0, 0, 32'h000, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 1, 1, 32'h00C, 32'h010, 0, 32'h000, 0, 0, 32'h000, 0, 4'b0001, 0, 0, 0, 0); // csrsi+csrci
    add(0, 1, 4'b0001, 0, 0, 0, 0, 32'h010, 32'h014, 0, 32'h000, 0, 0, 32'h000, 0, 4'b0001, 0, 0, 0, 0); // csrci won
    add(0, 0, 4'b0001, 0, 0, 1, 0, 32'h014, 32'h018, 0, 32'h000, 0, 0, 32'h000, 0, 4'b0001, 0, 0, 0, 0); // stalled csrsi
    add(0, 1, 4'b0001, 0, 0, 1, 0, 32'h014, 32'h018, 0, 32'h000, 0, 0, 32'h000, 0, 4'b0001, 0, 0, 0, 0); // csrsi, old mie
    add(0, 0, 4'b0001, 0, 0, 0, 0, 32'h018, 32'h01C, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0001, 0, 0, 0, 0); // stall
    add(0, 0, 4'b0001, 0, 0, 0, 0, 32'h018, 32'h01C, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0001, 0, 0, 0, 0);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 32'h4FC, 32'h500, 1, 32'h100, 1, 0, 32'h000, 1, 4'b0001, 0, 0, 0, 0); // resumes, taken
    add(0, 1, 4'b0000, 0, 0, 0, 0, 32'h100, 32'h104, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 1, 1, 0, 0);
    add(0, 1, 4'b0000, 1, 1, 0, 0, 32'h600, 32'h604, 1, 32'h080, 5, 0, 32'h000, 1, 4'b0000, 1, 1, 0, 0); // ecall+uret
    add(0, 1, 4'b0100, 0, 0, 0, 0, 32'h080, 32'h084, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0000, 2, 5, 0, 0);
    add(0, 1, 4'b0000, 0, 1, 0, 0, 32'h084, 32'h088, 0, 32'h000, 0, 1, 32'h604, 1, 4'b0100, 2, 5, 0, 0);
    add(0, 1, 4'b0100, 0, 0, 0, 0, 32'h604, 32'h608, 1, 32'h108, 3, 0, 32'h000, 1, 4'b0100, 1, 1, 0, 0); // rise with take
    add(0, 1, 4'b0100, 0, 0, 0, 0, 32'h108, 32'h10C, 0, 32'h000, 0, 0, 32'h000, 1, 4'b0100, 2, 3, 0, 0); // stays pending

    drive(1, 0, 4'b0000, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].iv, vq[i].irq, vq[i].ec, vq[i].ur, vq[i].si, vq[i].ci,
            vq[i].pcc, vq[i].pcn);
      #1;
      chk("trap_take", i, 32'(bus.trap_take), 32'(vq[i].tt));
      if (vq[i].tt) begin
        chk("trap_pc", i, bus.trap_pc, vq[i].tpc);
        chk("trap_id", i, 32'(bus.trap_id), 32'(vq[i].tid));
      end
      chk("ret_take", i, 32'(bus.ret_take), 32'(vq[i].rt));
      if (vq[i].rt) chk("ret_pc", i, bus.ret_pc, vq[i].rpc);
      chk("mie", i, 32'(bus.mie), 32'(vq[i].mie));
      chk("pending", i, 32'(bus.pending), 32'(vq[i].pend));
      chk("depth", i, 32'(bus.depth), 32'(vq[i].dep));
      chk("active_level", i, 32'(bus.active_level), 32'(vq[i].al));
      chk("err_ovf", i, 32'(bus.err_ovf), 32'(vq[i].ovf));
      chk("err_udf", i, 32'(bus.err_udf), 32'(vq[i].udf));
    end

    // Stalled core must never be redirected; the first retiring cycle must take ch3.
    @(negedge clk); drive(1, 0, 4'b0000, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); drive(0, 1, 4'b0000, 0, 0, 1, 0, 32'h0, 32'h4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(0, 0, 4'b1000, 0, 0, 0, 0, 32'h700, 32'h704);
      #1;
      chk("stall_no_trap", 100 + k, 32'(bus.trap_take), 32'd0);
    end
    chk("stall_pending", 104, 32'(bus.pending), 32'h8);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        @(negedge clk); drive(0, 1, 4'b1000, 0, 0, 0, 0, 32'h700, 32'h704);
        #1;
        if (bus.trap_take) begin
          seen = 1'b1;
          chk("resume_trap_pc", 105, bus.trap_pc, 32'h10C);
          chk("resume_latency", 106, 32'(k), 32'd0);
        end
      end
      if (!seen) chk("resume_timeout", 107, 32'(bus.trap_take), 32'd1);
    end

    @(negedge clk);
    drive(0, 0, 4'b0000, 0, 0, 0, 0, 32'h0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trap_irq_ctrl.md
Name: trap_irq_ctrl

Overview:
- Parametrised trap and interrupt controller for the single-cycle RISC-V core.
- Sits beside the instruction decoder and consumes the decoded ecall/uret/csrsi/csrci strobes.
- Latches NUM_IRQ external interrupt lines and arbitrates them by fixed priority.
- Supports nested handlers through a return-address stack NEST_DEPTH deep, and drives PC redirects for trap entry and uret return.

Parameters:
- NUM_IRQ, 4, number of interrupt channels; higher index has higher priority.
- NEST_DEPTH, 3, return-stack entries, i.e. maximum nesting depth.
- XLEN, 32, PC width.
- VEC_BASE, 32'h0000_0100, channel i vector = VEC_BASE + 4*i.
- ECALL_VEC, 32'h0000_0080, ecall handler vector.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  current instruction retires this cycle; low = stalled.
- irq_req  in  NUM_IRQ  raw interrupt lines, level; rising edge requests.
- ecall  in  1  decoded ecall.
- uret  in  1  decoded uret.
- csrsi  in  1  decoded csrsi to the enable CSR; sets mie.
- csrci  in  1  decoded csrci to the enable CSR; clears mie.
- pc_cur  in  XLEN  PC of the current instruction.
- pc_next  in  XLEN  sequential/branch next PC of the current instruction.
- trap_take  out  1  redirect PC to trap_pc this cycle.
- trap_pc  out  XLEN  handler vector.
- trap_id  out  clog2(NUM_IRQ+2)  level being entered.
- ret_take  out  1  redirect PC to ret_pc this cycle.
- ret_pc  out  XLEN  popped return address.
- mie  out  1  global interrupt enable.
- pending  out  NUM_IRQ  latched requests.
- depth  out  clog2(NEST_DEPTH+1)  stack occupancy.
- active_level  out  clog2(NUM_IRQ+2)  level of the top frame.
- err_ovf  out  1  sticky: trap dropped because the stack was full.
- err_udf  out  1  sticky: uret executed with an empty stack.

Behaviour:
- Level encoding:
  - 0 = no handler.
  - Channel i = i+1.
  - ecall = NUM_IRQ+1, the highest level; it blocks all interrupts until its uret.
- Reset (rst high at a clk edge): pending=0, mie=0, depth=0, active_level=0, err_ovf=0, err_udf=0.
  - The edge-detect registers load the current irq_req, so lines already high at reset do not request.
  - Stack contents are don't-care.
  - Reset mid-handler abandons all frames.
- Edge detect and pending:
  - pending[i] sets on the clk edge after the cycle in which irq_req[i] is 1 and was 0 in the previous cycle.
  - pending[i] clears on the edge at which channel i is taken.
  - If a new rising edge coincides with the take, pending[i] stays 1.
- All redirect outputs are combinational, valid only when instr_valid=1. State updates on the following clk edge.
- Precedence within one cycle: ecall > uret > interrupt.
  - If ecall and uret are both high, only ecall acts.
  - An interrupt that would otherwise be taken while ecall or uret is high is deferred; it stays pending and no error is flagged.
- ecall:
  - If depth<NEST_DEPTH: trap_take=1, trap_pc=ECALL_VEC, trap_id=NUM_IRQ+1. The edge pushes {pc_cur+4, NUM_IRQ+1}.
  - If the stack is full: no redirect, err_ovf sets, and ecall is treated as a nop.
  - ecall ignores mie.
- uret:
  - If depth>0: ret_take=1, ret_pc=top.pc. The edge pops.
  - If depth=0: no redirect and err_udf sets.
- Interrupt take:
  - Candidate c = highest i with pending[i]=1.
  - Taken iff instr_valid && mie && pending!=0 && (c+1)>active_level && depth<NEST_DEPTH && !ecall && !uret.
  - When taken: trap_take=1, trap_pc=VEC_BASE+4*c, trap_id=c+1. The edge pushes {pc_next, c+1} and clears pending[c].
  - If blocked only by a full stack: no redirect, no error, and the request remains pending.
- The current instruction always retires, so interrupt return resumes at pc_next.
- csrsi/csrci update mie at the edge.
  - If both are high, csrci wins.
  - The enable change affects take decisions from the next cycle on; the take decision in the same cycle uses the old mie.
- mie is not altered by trap entry or return; nesting is controlled purely by level.
- active_level = level field of the top entry, or 0 when depth=0.
- instr_valid=0: no redirect, no push/pop, mie unchanged; edge detect and pending still update.
- Address arithmetic is modulo 2^XLEN.

Test Plan:
- Reset, irq_req=4'b0000, then raise irq_req[1] with mie=1 and pc_next=0x40 -> pending[1]=1 one edge later; next cycle trap_take=1, trap_pc=0x104, trap_id=2; after that edge depth=1 and pending=0.
- Inside the channel-1 handler, raise irq_req[3] and then irq_req[0] -> ch3 nests (trap_pc=0x10C, depth=2); ch0 stays pending until both urets. The urets return ret_pc of ch3's pushed pc_next and then 0x40, after which ch0 is taken.
- ecall at pc_cur=0x200 while pending[2]=1 and mie=1 -> trap_pc=0x80 and return 0x204 is pushed; ch2 is held until uret, then taken in the cycle after the uret.
- Fill the stack to NEST_DEPTH=3, then issue ecall -> no trap_take, err_ovf=1; depth stays 3.
- uret with depth=0 -> ret_take=0, err_udf=1. Then apply rst -> all outputs return to 0.
- csrsi and csrci high in the same cycle while pending[0]=1 -> mie=0 and no trap; instr_valid=0 with a pending request -> no trap until instr_valid returns.
